// File: rtl/ca_pkg.sv
// Shared types and constants for the 1-D cellular-automaton row sequencer.
package ca_pkg;

    localparam int CA_W  = 640;
    localparam int CA_H  = 480;
    localparam int CA_AW = 19;

    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
    // Feedback taps at bits 31, 21, 1 and 0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_WRITE = 3'd2,
        ST_GEN   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return {cur[30:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ca_rule_next.sv
// Next generation of a W-cell wrapping automaton under an 8-bit Wolfram rule.
module ca_rule_next
    import ca_pkg::*;
#(
    parameter int W = CA_W
) (
    input  logic [W-1:0] cur,
    input  logic [7:0]   rule,
    output logic [W-1:0] next
);

    // The left neighbour (lower index) forms the MSB of the rule index; edges wrap.
    for (genvar i = 0; i < W; i++) begin : g_cell
        localparam int LEFT  = (i + W - 1) % W;
        localparam int RIGHT = (i + 1) % W;
        assign next[i] = rule[{cur[LEFT], cur[i], cur[RIGHT]}];
    end

endmodule

// File: rtl/ca_row_sequencer.sv
// Seeds, writes and evolves automaton generations into a 1-bit frame buffer, one row per generation.
module ca_row_sequencer
    import ca_pkg::*;
#(
    parameter int W      = CA_W,
    parameter int H      = CA_H,
    parameter int AW     = CA_AW,
    parameter int CENTER = W / 2
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iStart,
    input  logic          iStep,
    input  logic          iRun,
    input  logic [7:0]    iRule,
    input  logic          iSeedMode,
    output logic [AW-1:0] oAddr,
    output logic          oData,
    output logic          oWe,
    output logic [8:0]    oRow,
    output logic [2:0]    oState,
    output logic          oDone
);

    localparam int              CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]   COL_LAST = CW'(W - 1);
    localparam logic [8:0]      ROW_LAST = 9'(H - 1);
    localparam logic [W-1:0]    SEED_ONE = W'(1) << CENTER;

    state_e          state_r;
    logic [8:0]      row_r;
    logic [CW-1:0]   col_r;
    logic [AW-1:0]   addr_r;
    logic [W-1:0]    cur_r;
    logic [31:0]     lfsr_r;
    logic            seed_mode_r;
    logic            run_d_r;
    logic            we_r;
    logic            data_r;
    logic            done_r;
    logic [W-1:0]    next_gen_s;
    logic            step_go_s;

    ca_rule_next #(.W(W)) u_rule_next (
        .cur  (cur_r),
        .rule (iRule),
        .next (next_gen_s)
    );

    // Advance out of WAIT on a step pulse or when free-run is switched on.
    always_comb begin
        step_go_s = iStep | (iRun & ~run_d_r);
    end

    // Sequencer FSM; the port-A outputs are registered alongside the state so they line up with it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r     <= ST_IDLE;
            row_r       <= 9'd0;
            col_r       <= '0;
            addr_r      <= '0;
            cur_r       <= '0;
            lfsr_r      <= LFSR_SEED;
            seed_mode_r <= 1'b0;
            run_d_r     <= 1'b0;
            we_r        <= 1'b0;
            data_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            lfsr_r  <= lfsr_next(lfsr_r);
            run_d_r <= iRun;
            if (iStart) begin
                state_r     <= ST_SEED;
                row_r       <= 9'd0;
                col_r       <= '0;
                addr_r      <= '0;
                cur_r       <= '0;
                seed_mode_r <= iSeedMode;
                we_r        <= 1'b0;
                data_r      <= 1'b0;
                done_r      <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        we_r   <= 1'b0;
                        data_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                    ST_SEED: begin
                        if (!seed_mode_r) begin
                            cur_r[CENTER] <= 1'b1;
                            state_r       <= ST_WRITE;
                            we_r          <= 1'b1;
                            data_r        <= SEED_ONE[0];
                        end else begin
                            // Random row: one LFSR bit per cycle; cell 0 is already loaded by the last cycle
                            cur_r[col_r] <= lfsr_r[0];
                            if (col_r == COL_LAST) begin
                                state_r <= ST_WRITE;
                                col_r   <= '0;
                                we_r    <= 1'b1;
                                data_r  <= cur_r[0];
                            end else begin
                                col_r <= col_r + CW'(1);
                            end
                        end
                    end
                    ST_WRITE: begin
                        addr_r <= addr_r + AW'(1);
                        if (col_r == COL_LAST) begin
                            we_r   <= 1'b0;
                            data_r <= 1'b0;
                            if (row_r == ROW_LAST) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else if (iRun) begin
                                state_r <= ST_GEN;
                            end else begin
                                state_r <= ST_WAIT;
                            end
                        end else begin
                            col_r  <= col_r + CW'(1);
                            we_r   <= 1'b1;
                            data_r <= cur_r[col_r + CW'(1)];
                        end
                    end
                    ST_WAIT: begin
                        we_r <= 1'b0;
                        if (step_go_s) begin
                            state_r <= ST_GEN;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end
                    ST_GEN: begin
                        cur_r   <= next_gen_s;
                        row_r   <= row_r + 9'd1;
                        col_r   <= '0;
                        state_r <= ST_WRITE;
                        we_r    <= 1'b1;
                        data_r  <= next_gen_s[0];
                    end
                    ST_DONE: begin
                        we_r   <= 1'b0;
                        data_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        we_r    <= 1'b0;
                        data_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign oAddr  = addr_r;
    assign oData  = data_r;
    assign oWe    = we_r;
    assign oRow   = row_r;
    assign oState = state_r;
    assign oDone  = done_r;

endmodule

// File: tb/tb_ca_row_sequencer.sv
// Scoreboard bench for ca_row_sequencer on a reduced screen, with a behavioural automaton/LFSR model.
module tb_ca_row_sequencer;

    localparam int TW  = 16;
    localparam int TH  = 12;
    localparam int TAW = 8;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic           clk;
    logic           iRST, iStart, iStep, iRun, iSeedMode;
    logic [7:0]     iRule;
    logic [TAW-1:0] oAddr;
    logic           oData, oWe, oDone;
    logic [8:0]     oRow;
    logic [2:0]     oState;

    int  errors = 0;
    int  checks = 0;
    int  wr_count = 0;
    int  cyc = 0;
    wr_t exp_q[$];
    wr_t e_m;
    int  cells[TW];
    int  nxt[TW];

    ca_row_sequencer #(.W(TW), .H(TH), .AW(TAW), .CENTER(TW / 2)) dut (
        .iCLK      (clk),
        .iRST      (iRST),
        .iStart    (iStart),
        .iStep     (iStep),
        .iRun      (iRun),
        .iRule     (iRule),
        .iSeedMode (iSeedMode),
        .oAddr     (oAddr),
        .oData     (oData),
        .oWe       (oWe),
        .oRow      (oRow),
        .oState    (oState),
        .oDone     (oDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of non-reset clock edges since the last reset (the LFSR step count).
    always @(posedge clk) begin
        if (iRST) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Monitor: every write presented by the DUT must be the next expected one.
    always @(negedge clk) begin
        if (!iRST && oWe) begin
            checks++;
            wr_count++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%0d", oAddr, oData);
            end else begin
                e_m = exp_q.pop_front();
                if (int'(oAddr) != e_m.addr || int'(oData) != e_m.data) begin
                    errors++;
                    $display("FAIL write actual addr=%0d data=%0d expected addr=%0d data=%0d",
                             oAddr, oData, e_m.addr, e_m.data);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    task automatic seed_single();
        for (int c = 0; c < TW; c++) cells[c] = 0;
        cells[TW / 2] = 1;
    endtask

    task automatic seed_lfsr(input int s);
        logic [31:0] l = 32'h0000_0001;
        for (int i = 0; i < s; i++) l = lfsr_step(l);
        for (int k = 0; k < TW; k++) begin
            cells[k] = int'(l[0]);
            l = lfsr_step(l);
        end
    endtask

    // Expected writes for a whole frame starting from the seed row in cells.
    task automatic push_frame(input int rule);
        int idx;
        for (int r = 0; r < TH; r++) begin
            for (int c = 0; c < TW; c++) exp_q.push_back('{addr: r * TW + c, data: cells[c]});
            for (int c = 0; c < TW; c++) begin
                idx = 4 * cells[(c + TW - 1) % TW] + 2 * cells[c] + cells[(c + 1) % TW];
                nxt[c] = (rule >> idx) & 1;
            end
            cells = nxt;
        end
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
        exp_q.delete();
        wr_count = 0;
    endtask

    task automatic start_frame(input int mode, input int rule, input int run);
        int s;
        iSeedMode = mode[0];
        iRule     = rule[7:0];
        iRun      = run[0];
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        s = cyc;
        exp_q.delete();
        wr_count = 0;
        if (mode == 0) seed_single();
        else           seed_lfsr(s);
        push_frame(rule);
        chk("start_state", int'(oState), 1);
        chk("start_we", int'(oWe), 0);
        chk("start_addr", int'(oAddr), 0);
        chk("start_row", int'(oRow), 0);
    endtask

    task automatic wait_done(output int cnt, output int first);
        cnt = 0;
        first = -1;
        while (!oDone && cnt < 2000) begin
            tick();
            cnt++;
            if (first < 0 && oWe) first = cnt;
        end
    endtask

    task automatic check_frame_end(input string tag);
        chk({tag, "_done"}, int'(oDone), 1);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        chk({tag, "_writes"}, wr_count, TW * TH);
    endtask

    // Free-run frame from the start edge: latency to first write and to oDone.
    task automatic run_free(input int mode, input string tag);
        int cnt, first, seed_len;
        seed_len = (mode == 0) ? 1 : TW;
        wait_done(cnt, first);
        chk({tag, "_first_write"}, first, seed_len);
        chk({tag, "_frame_cycles"}, cnt, seed_len + TW * TH + (TH - 1));
        check_frame_end(tag);
    endtask

    initial begin
        int cnt, first, quiet, c, mode, rule;
        iRST = 1'b0; iStart = 1'b0; iStep = 1'b0; iRun = 1'b0;
        iSeedMode = 1'b0; iRule = 8'd0;

        do_reset();
        chk("reset_we", int'(oWe), 0);
        chk("reset_addr", int'(oAddr), 0);
        chk("reset_state", int'(oState), 0);
        chk("reset_done", int'(oDone), 0);
        chk("reset_row", int'(oRow), 0);

        start_frame(0, 90, 1);
        run_free(0, "rule90");

        // DONE holds and ignores iStep
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        repeat (3) tick();
        chk("done_hold_state", int'(oState), 5);
        chk("done_hold_done", int'(oDone), 1);
        chk("done_hold_we", int'(oWe), 0);

        start_frame(0, 2, 1);
        run_free(0, "rule2_wrap");

        for (int n = 0; n < 4; n++) begin
            mode = int'($urandom_range(1, 0));
            rule = int'($urandom_range(255, 0));
            start_frame(mode, rule, 1);
            run_free(mode, "random");
        end

        // Single-step: four iStep pulses, then switch to free-run from WAIT
        start_frame(0, int'($urandom_range(255, 0)), 0);
        repeat (TW + 1) tick();
        for (int r = 0; r < 5; r++) begin
            chk("step_wait_state", int'(oState), 4);
            chk("step_wait_row", int'(oRow), r);
            quiet = 0;
            repeat (30) begin
                tick();
                if (oWe || oState != 3'd4) quiet++;
            end
            chk("step_wait_quiet", quiet, 0);
            if (r < 4) begin
                iStep = 1'b1;
                tick();
                iStep = 1'b0;
                chk("step_gen_state", int'(oState), 3);
                chk("step_gen_we", int'(oWe), 0);
                repeat (TW + 1) tick();
            end else begin
                iRun = 1'b1;
                tick();
                chk("run_rise_gen", int'(oState), 3);
            end
        end
        wait_done(cnt, first);
        check_frame_end("step");

        // Abort mid-WRITE with iStart at row 5
        start_frame(0, int'($urandom_range(255, 0)), 1);
        c = int'($urandom_range(TW - 2, 1));
        repeat (1 + 5 * (TW + 1) + c) tick();
        chk("abort_pre_we", int'(oWe), 1);
        chk("abort_pre_row", int'(oRow), 5);
        chk("abort_pre_addr", int'(oAddr), 5 * TW + c);
        start_frame(0, int'($urandom_range(255, 0)), 1);
        run_free(0, "abort_restart");

        // Reset in the middle of row 2
        start_frame(1, int'($urandom_range(255, 0)), 1);
        repeat (TW + 2 * (TW + 1) + 3) tick();
        chk("rst_pre_we", int'(oWe), 1);
        iRST = 1'b1;
        tick();
        chk("rst_mid_we", int'(oWe), 0);
        chk("rst_mid_addr", int'(oAddr), 0);
        chk("rst_mid_state", int'(oState), 0);
        chk("rst_mid_done", int'(oDone), 0);
        iRST = 1'b0;
        exp_q.delete();
        iStep = 1'b1;
        tick();
        iStep = 1'b0;
        repeat (4) tick();
        chk("idle_hold_state", int'(oState), 0);
        chk("idle_hold_we", int'(oWe), 0);

        // Random seed row right after reset, LFSR phase set by a random delay
        do_reset();
        repeat (int'($urandom_range(20, 0))) tick();
        start_frame(1, int'($urandom_range(255, 0)), 1);
        run_free(1, "lfsr_seed");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
